// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a reload value down to zero, pulses done,
// then either stops or reloads. Supports pause, abort (stop) and synchronous load.
module down_counter_timer #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] MAX_COUNT = 12'd15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= MAX_COUNT;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

    // Input priority is load > stop > start > pause; done is only ever a single-cycle pulse.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        if (load) begin
            reload_nxt = load_value;
            count_nxt  = load_value;
            state_nxt  = IDLE;
        end else if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reload_reg != '0) begin
                            count_nxt = reload_reg;
                            state_nxt = RUN;
                        end else begin
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (count == '0) begin
                        // Only reachable after an auto-reload terminal count.
                        count_nxt = reload_reg;
                    end else if (count == WIDTH'(1)) begin
                        count_nxt = '0;
                        done_nxt  = 1'b1;
                        if (!auto_reload) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        count_nxt = count - WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy   = (state == RUN) || (state == PAUSED);
    assign paused = (state == PAUSED);
    assign zero   = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios with constant
// expectations plus a randomized run against a behavioural timer model.
module tb_down_counter_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [11:0] load_value;
    logic        start;
    logic        stop;
    logic        pause;
    logic        auto_reload;
    logic [11:0] count;
    logic        busy;
    logic        paused;
    logic        done;
    logic        zero;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = idle, 1 = counting, 2 = frozen
    int          m_mode;
    logic [11:0] m_count;
    logic [11:0] m_reload;
    logic        m_done;

    down_counter_timer #(.WIDTH(12), .MAX_COUNT(12'd15)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .start(start),
        .stop(stop),
        .pause(pause),
        .auto_reload(auto_reload),
        .count(count),
        .busy(busy),
        .paused(paused),
        .done(done),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_mode   = 0;
        m_count  = 12'd0;
        m_reload = 12'd15;
        m_done   = 1'b0;
    endtask

    // Advance one clock edge and apply the timer rules to the model; inputs are stable across the edge.
    task automatic step();
        logic [11:0] nxt;
        @(posedge clk);
        m_done = 1'b0;
        if (load) begin
            m_reload = load_value;
            m_count  = load_value;
            m_mode   = 0;
        end else if (stop) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_count = m_reload;
                if (m_reload == 12'd0) m_done = 1'b1;
                else m_mode = 1;
            end
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end else if (pause) begin
            m_mode = 2;
        end else begin
            nxt = (m_count == 12'd0) ? m_reload : m_count - 12'd1;
            if (nxt == 12'd0) begin
                m_done = 1'b1;
                if (!auto_reload) m_mode = 0;
            end
            m_count = nxt;
        end
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (count !== 12'd0 || busy !== 1'b0 || paused !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_state: count=%0d busy=%0b paused=%0b done=%0b zero=%0b expected 0 0 0 0 1",
                     count, busy, paused, done, zero);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_oneshot();
        auto_reload = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 12'd15 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oneshot_start: count=%0d busy=%0b done=%0b expected 15 1 0", count, busy, done);
        end
        for (int k = 14; k >= 0; k--) begin
            step();
            total++;
            if (count !== 12'(k) || done !== (k == 0) || busy !== (k != 0)) begin
                bad++;
                $display("[TB] FAIL oneshot_count: count=%0d done=%0b busy=%0b expected %0d %0b %0b",
                         count, done, busy, k, (k == 0), (k != 0));
            end
        end
        step();
        total++;
        if (count !== 12'd0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oneshot_after: count=%0d done=%0b busy=%0b expected 0 0 0", count, done, busy);
        end
    endtask

    task automatic test_stop();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        total++;
        if (count !== 12'd4) begin
            bad++;
            $display("[TB] FAIL stop_pre: count=%0d expected 4", count);
        end
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        total++;
        if (count !== 12'd4 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_abort: count=%0d busy=%0b done=%0b expected 4 0 0", count, busy, done);
        end
        step();
        total++;
        if (count !== 12'd4 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_hold: count=%0d busy=%0b expected 4 0", count, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 12'd15 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stop_restart: count=%0d busy=%0b expected 15 1", count, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_auto_reload();
        load = 1'b1;
        load_value = 12'd5;
        step();
        load = 1'b0;
        auto_reload = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 12'd5 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL auto_start: count=%0d busy=%0b expected 5 1", count, busy);
        end
        for (int i = 1; i <= 13; i++) begin
            step();
            total++;
            if (count !== 12'(5 - (i % 6)) || done !== ((i % 6) == 5) || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL auto_period: cycle=%0d count=%0d done=%0b busy=%0b expected %0d %0b 1",
                         i, count, done, busy, 5 - (i % 6), ((i % 6) == 5));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_pause();
        load = 1'b1;
        load_value = 12'd10;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (count !== 12'd7 || paused !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL pause_hold: count=%0d paused=%0b busy=%0b expected 7 1 1", count, paused, busy);
            end
        end
        pause = 1'b0;
        step();
        total++;
        if (count !== 12'd7 || paused !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pause_resume: count=%0d paused=%0b busy=%0b expected 7 0 1", count, paused, busy);
        end
        for (int k = 6; k >= 5; k--) begin
            step();
            total++;
            if (count !== 12'(k)) begin
                bad++;
                $display("[TB] FAIL pause_after: count=%0d expected %0d", count, k);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_load_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++;
        if (count !== 12'd9) begin
            bad++;
            $display("[TB] FAIL loadstart_pre: count=%0d expected 9", count);
        end
        load = 1'b1;
        start = 1'b1;
        load_value = 12'd3;
        step();
        load = 1'b0;
        start = 1'b0;
        total++;
        if (count !== 12'd3 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL loadstart_load: count=%0d busy=%0b done=%0b expected 3 0 0", count, busy, done);
        end
        load = 1'b1;
        load_value = 12'd0;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 12'd0 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_reload_pulse: count=%0d done=%0b busy=%0b expected 0 1 0", count, done, busy);
        end
        step();
        total++;
        if (count !== 12'd0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_reload_after: count=%0d done=%0b busy=%0b expected 0 0 0", count, done, busy);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1;
        load_value = 12'd12;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (count !== 12'd8 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL areset_pre: count=%0d busy=%0b expected 8 1", count, busy);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (count !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL areset_now: count=%0d busy=%0b done=%0b expected 0 0 0", count, busy, done);
        end
        #1;
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 12'd15 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL areset_restart: count=%0d busy=%0b expected 15 1", count, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load        = ($urandom_range(99) < 4);
            stop        = ($urandom_range(99) < 4);
            start       = ($urandom_range(99) < 25);
            pause       = ($urandom_range(99) < 15);
            auto_reload = ($urandom_range(99) < 60);
            load_value  = 12'($urandom_range(8));
            step();
            total++;
            if (count !== m_count || busy !== (m_mode != 0) || paused !== (m_mode == 2) ||
                done !== m_done || zero !== (m_count == 12'd0)) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d: count=%0d busy=%0b paused=%0b done=%0b zero=%0b expected %0d %0b %0b %0b %0b",
                         i, count, busy, paused, done, zero, m_count, (m_mode != 0), (m_mode == 2),
                         m_done, (m_count == 12'd0));
            end
        end
        load = 1'b0;
        stop = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        load        = 1'b0;
        load_value  = 12'd0;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_oneshot();
        test_stop();
        test_auto_reload();
        test_pause();
        test_load_start();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
